// File: rtl/key_schedule_inv_seq_if.sv
// Key-schedule streaming port: start/kin request side plus the valid/ready round-key stream.
// With LASTKEY_IN_EN defined the request also carries kin_is_last.
interface key_schedule_inv_seq_if #(
    parameter int CW = 8
);
    logic         start;
    logic [127:0] kin;
`ifdef LASTKEY_IN_EN
    logic         kin_is_last;
`endif
    logic         busy;
    logic [127:0] kout;
    logic [CW-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         done;

`ifdef LASTKEY_IN_EN
    modport master (output start, kin, kin_is_last, out_ready,
                    input  busy, kout, out_idx, out_valid, done);
    modport slave  (input  start, kin, kin_is_last, out_ready,
                    output busy, kout, out_idx, out_valid, done);
`else
    modport master (output start, kin, out_ready,
                    input  busy, kout, out_idx, out_valid, done);
    modport slave  (input  start, kin, out_ready,
                    output busy, kout, out_idx, out_valid, done);
`endif
endinterface

// File: rtl/key_schedule_inv_seq.sv
// Runs the forward key schedule ROUNDS steps, then streams k(ROUNDS)..k(0) via the inverse step.
// Optional LASTKEY_IN_EN: kin_is_last lets the caller supply k(ROUNDS) directly and skip FWD.
module key_schedule_inv_seq #(
    parameter int ROUNDS = 32,
    parameter int CW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    key_schedule_inv_seq_if.slave ks
);
    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    state_t        state;
    logic [127:0]  kreg;
    logic [CW-1:0] cnt;
    logic          vld;
    logic          busy_r;
    logic          done_r;

    function automatic logic [127:0] p_step(input logic [127:0] k);
        return {k[19:0], k[127:36], k[20], k[35:21]};
    endfunction

    function automatic logic [127:0] pinv_step(input logic [127:0] k);
        return {k[107:16], k[14:0], k[15], k[127:108]};
    endfunction

    // kreg doubles as the output register; its value only matters while vld is high
    assign ks.kout      = kreg;
    assign ks.out_idx   = cnt;
    assign ks.out_valid = vld;
    assign ks.busy      = busy_r;
    assign ks.done      = done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            kreg   <= '0;
            cnt    <= '0;
            vld    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (ks.start) begin
                        kreg   <= ks.kin;
                        busy_r <= 1'b1;
`ifdef LASTKEY_IN_EN
                        if (ks.kin_is_last) begin
                            cnt   <= CW'(ROUNDS);
                            vld   <= 1'b1;
                            state <= REV;
                        end else begin
                            cnt   <= '0;
                            state <= FWD;
                        end
`else
                        cnt   <= '0;
                        state <= FWD;
`endif
                    end
                end
                FWD: begin
                    kreg <= p_step(kreg);
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ROUNDS - 1)) begin
                        vld   <= 1'b1;
                        state <= REV;
                    end
                end
                REV: begin
                    // vld is always high here, so out_ready alone completes the handshake
                    if (ks.out_ready) begin
                        if (cnt != '0) begin
                            kreg <= pinv_step(kreg);
                            cnt  <= cnt - 1'b1;
                        end else begin
                            vld    <= 1'b0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_schedule_inv_seq.sv
// Bench: fixed ROUNDS=2 vector table plus randomized ROUNDS=32 runs against a forward-key-list model.
module tb_key_schedule_inv_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2, rst32;
    int errs = 0;
    int checks = 0;

    key_schedule_inv_seq_if #(.CW(8)) a ();
    key_schedule_inv_seq_if #(.CW(8)) b ();

    key_schedule_inv_seq #(.ROUNDS(2),  .CW(8)) dut2  (.clk(clk), .rst(rst2),  .ks(a.slave));
    key_schedule_inv_seq #(.ROUNDS(32), .CW(8)) dut32 (.clk(clk), .rst(rst32), .ks(b.slave));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: forward rule only; the reverse stream is the stored list read backwards
    function automatic logic [127:0] p_fn(input logic [127:0] k);
        return {k[19:0], k[127:36], k[20], k[35:21]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic [127:0]       kin;
        logic [2:0][127:0]  exp;   // exp[i] = key with out_idx i
    } vec_t;

    vec_t tbl[5];

    task automatic run32(input logic [127:0] k0, input bit last, input bit bp,
                         input bit noise, input int abort_at);
        logic [127:0] keys[33];
        int c, n, lat_exp;
        bit first, finished;
        keys[0] = k0;
        for (int i = 1; i <= 32; i++) keys[i] = p_fn(keys[i-1]);
        lat_exp = last ? 1 : 33;
        @(negedge clk);
        b.start = 1'b1;
        b.kin = last ? keys[32] : k0;
`ifdef LASTKEY_IN_EN
        b.kin_is_last = last;
`endif
        b.out_ready = 1'b0;
        @(negedge clk);
        b.start = 1'b0;
        b.kin = rnd128();
`ifdef LASTKEY_IN_EN
        b.kin_is_last = 1'b0;
`endif
        c = 1; n = 0; first = 1'b1; finished = 1'b0;
        while (!finished && c < 400) begin
            chk("busy_run", 128'(b.busy), 128'(1));
            chk("no_early_done", 128'(b.done), 128'(0));
            if (b.out_valid) begin
                if (first) begin
                    chk("latency", 128'(c), 128'(lat_exp));
                    first = 1'b0;
                end
                chk("kout", b.kout, keys[32-n]);
                chk("idx", 128'(b.out_idx), 128'(32-n));
                if (32 - n == abort_at) begin
                    rst32 = 1'b1;
                    b.start = 1'b0;
                    @(negedge clk);
                    rst32 = 1'b0;
                    chk("abort_valid", 128'(b.out_valid), 128'(0));
                    chk("abort_busy", 128'(b.busy), 128'(0));
                    chk("abort_kout", b.kout, 128'(0));
                    chk("abort_idx", 128'(b.out_idx), 128'(0));
                    chk("abort_done", 128'(b.done), 128'(0));
                    @(negedge clk);
                    chk("abort_done2", 128'(b.done), 128'(0));
                    finished = 1'b1;
                    continue;
                end
                b.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b.out_ready) begin
                    n++;
                    if (n == 33) begin
                        // a start coinciding with the final handshake must be ignored
                        b.start = noise;
                        b.kin = rnd128();
                        @(negedge clk);
                        b.start = 1'b0;
                        b.out_ready = 1'b0;
                        chk("done_pulse", 128'(b.done), 128'(1));
                        chk("end_valid", 128'(b.out_valid), 128'(0));
                        chk("end_busy", 128'(b.busy), 128'(0));
                        @(negedge clk);
                        chk("done_once", 128'(b.done), 128'(0));
                        chk("idle_busy", 128'(b.busy), 128'(0));
                        finished = 1'b1;
                        continue;
                    end
                end
            end else begin
                chk("valid_held", 128'(first), 128'(1));
            end
            b.start = noise && ($urandom_range(0, 3) == 0);
            b.kin = rnd128();
            @(negedge clk);
            c++;
        end
        b.start = 1'b0;
        if (!finished) chk("timeout32", 128'(0), 128'(1));
    endtask

    initial begin
        int c;
        logic [127:0] kk;
        tbl[0].kin = 128'h1;
        tbl[0].exp = {128'h00000000010000000000000000000000,
                      128'h00001000000000000000000000000000, 128'h1};
        tbl[1].kin = 128'h0;
        tbl[1].exp = {128'h0, 128'h0, 128'h0};
        tbl[2].kin = {128{1'b1}};
        tbl[2].exp = {{128{1'b1}}, {128{1'b1}}, {128{1'b1}}};
        tbl[3].kin = 128'h1 << 127;
        tbl[3].exp = {128'h1 << 87, 128'h1 << 107, 128'h1 << 127};
        tbl[4].kin = 128'h1 << 20;
        tbl[4].exp = {128'h1 << 123, 128'h1 << 15, 128'h1 << 20};

        rst2 = 1'b1; rst32 = 1'b1;
        a.start = 1'b0; a.kin = '0; a.out_ready = 1'b1;
        b.start = 1'b0; b.kin = '0; b.out_ready = 1'b0;
`ifdef LASTKEY_IN_EN
        a.kin_is_last = 1'b0;
        b.kin_is_last = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_kout", b.kout, 128'(0));
        chk("rst_idx", 128'(b.out_idx), 128'(0));
        chk("rst_valid", 128'(b.out_valid), 128'(0));
        chk("rst_busy", 128'(b.busy), 128'(0));
        chk("rst_done", 128'(b.done), 128'(0));
        chk("rst2_valid", 128'(a.out_valid), 128'(0));
        rst2 = 1'b0; rst32 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a.start = 1'b1;
            a.kin = tbl[i].kin;
            @(negedge clk);
            a.start = 1'b0;
            a.kin = rnd128();
            c = 1;
            while (!a.out_valid && c < 20) begin
                @(negedge clk);
                c++;
            end
            chk("r2_latency", 128'(c), 128'(3));
            for (int j = 2; j >= 0; j--) begin
                chk("r2_kout", a.kout, tbl[i].exp[j]);
                chk("r2_idx", 128'(a.out_idx), 128'(j));
                chk("r2_valid", 128'(a.out_valid), 128'(1));
                @(negedge clk);
            end
            chk("r2_done", 128'(a.done), 128'(1));
            chk("r2_end_valid", 128'(a.out_valid), 128'(0));
            @(negedge clk);
            chk("r2_done_once", 128'(a.done), 128'(0));
        end

        kk = rnd128();
        run32(kk, 1'b0, 1'b0, 1'b0, -1);
        run32(rnd128(), 1'b0, 1'b1, 1'b0, -1);
        run32(rnd128(), 1'b0, 1'b1, 1'b1, -1);
        run32(rnd128(), 1'b0, 1'b1, 1'b0, 17);
        run32(rnd128(), 1'b0, 1'b0, 1'b1, -1);
`ifdef LASTKEY_IN_EN
        run32(kk, 1'b1, 1'b0, 1'b0, -1);
        run32(rnd128(), 1'b1, 1'b1, 1'b1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
